// File: rtl/qvalue_update_if.sv
// Memory port of qvalue_update: byte-addressed bus of 16-bit words.
interface qvalue_update_if;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_in;
  logic [15:0] data_out;

  modport master (output address, output wr_en, output data_out, input data_in);
  modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/qvalue_update.sv
// One-shot Q-value update: find the chosen hop in the neighbor table, move its Q toward the reward.
// Optional macro UPDATE_BATTERY_EN adds a WR_BAT state that also stores the hop's battery status.
module qvalue_update #(
  parameter int ALPHA_SHIFT   = 2,
  parameter int MAX_NEIGHBORS = 64
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [15:0]           action,
  input  logic [15:0]           rwd,
  input  logic [15:0]           fbatteryStat,
  qvalue_update_if.master       mem,
  output logic                  found,
  output logic [15:0]           q_new,
  output logic                  done
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RD_CNT    = 4'd1,
    LATCH_CNT = 4'd2,
    RD_ID     = 4'd3,
    CMP_ID    = 4'd4,
    RD_Q      = 4'd5,
    CALC      = 4'd6,
    WR_Q      = 4'd7,
`ifdef UPDATE_BATTERY_EN
    WR_BAT    = 4'd8,
`endif
    DONE      = 4'd9
  } state_t;

  localparam logic [15:0] CNT_ADDR = 16'h068A;
  localparam logic [15:0] ID_BASE  = 16'h0048;
  localparam logic [15:0] Q_BASE   = 16'h01C8;
`ifdef UPDATE_BATTERY_EN
  localparam logic [15:0] BAT_BASE = 16'h0148;
`endif
  localparam logic [15:0] MAX_N    = 16'(MAX_NEIGHBORS);

  // Q moves toward the reward by a 2^-ALPHA_SHIFT fraction; the result stays between Q and rwd.
  function automatic logic [15:0] q_calc(input logic [15:0] q, input logic [15:0] r);
    logic [15:0] diff;
    if (r >= q) begin
      diff   = r - q;
      q_calc = q + (diff >> ALPHA_SHIFT);
    end else begin
      diff   = q - r;
      q_calc = q - (diff >> ALPHA_SHIFT);
    end
  endfunction

  state_t      state, state_nxt;
  logic [15:0] i_r, i_nxt;
  logic [15:0] cnt_r, cnt_nxt;
  logic        found_r, found_nxt;
  logic [15:0] q_new_r, q_new_nxt;
  logic [15:0] addr_r, addr_nxt;
  logic [15:0] dout_r, dout_nxt;
  logic        wr_r, wr_nxt;
  logic        done_r, done_nxt;
  logic [15:0] action_r, action_nxt;
  logic [15:0] rwd_r, rwd_nxt;
`ifdef UPDATE_BATTERY_EN
  logic [15:0] bat_r, bat_nxt;
`endif
  logic [15:0] cnt_clamp;
  logic        id_hit;

  assign cnt_clamp = (mem.data_in > MAX_N) ? MAX_N : mem.data_in;
  assign id_hit    = (mem.data_in == action_r);

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; en low freezes the FSM.
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:      if (start && !done_r) state_nxt = RD_CNT; else state_nxt = IDLE;
        RD_CNT:    state_nxt = LATCH_CNT;
        LATCH_CNT: if (cnt_clamp == 16'd0) state_nxt = DONE; else state_nxt = RD_ID;
        RD_ID:     state_nxt = CMP_ID;
        CMP_ID: begin
          if (id_hit)                    state_nxt = RD_Q;
          else if (i_r + 16'd1 < cnt_r)  state_nxt = RD_ID;
          else                           state_nxt = DONE;
        end
        RD_Q:      state_nxt = CALC;
        CALC:      state_nxt = WR_Q;
`ifdef UPDATE_BATTERY_EN
        WR_Q:      state_nxt = WR_BAT;
        WR_BAT:    state_nxt = DONE;
`else
        WR_Q:      state_nxt = DONE;
`endif
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Datapath and output next values; bus outputs follow the state being entered.
  always_comb begin
    i_nxt      = i_r;
    cnt_nxt    = cnt_r;
    found_nxt  = found_r;
    q_new_nxt  = q_new_r;
    dout_nxt   = dout_r;
    action_nxt = action_r;
    rwd_nxt    = rwd_r;
`ifdef UPDATE_BATTERY_EN
    bat_nxt    = bat_r;
`endif
    addr_nxt   = 16'h0000;
    wr_nxt     = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (state_nxt == RD_CNT) begin
            action_nxt = action;
            rwd_nxt    = rwd;
`ifdef UPDATE_BATTERY_EN
            bat_nxt    = fbatteryStat;
`endif
          end else begin
            action_nxt = action_r;
          end
        end
        LATCH_CNT: begin
          cnt_nxt = cnt_clamp;
          i_nxt   = 16'd0;
        end
        CMP_ID: begin
          if (id_hit)                    found_nxt = 1'b1;
          else if (state_nxt == RD_ID)   i_nxt = i_r + 16'd1;
          else                           i_nxt = i_r;
        end
        CALC: begin
          q_new_nxt = q_calc(mem.data_in, rwd_r);
          dout_nxt  = q_new_nxt;
        end
`ifdef UPDATE_BATTERY_EN
        WR_Q:    dout_nxt = bat_r;
`endif
        default: dout_nxt = dout_r;
      endcase
    end else begin
      i_nxt = i_r;
    end
    case (state_nxt)
      RD_CNT, LATCH_CNT: addr_nxt = CNT_ADDR;
      RD_ID, CMP_ID:     addr_nxt = ID_BASE + (i_nxt << 1);
      RD_Q, CALC:        addr_nxt = Q_BASE + (i_nxt << 1);
      WR_Q: begin
        addr_nxt = Q_BASE + (i_nxt << 1);
        wr_nxt   = 1'b1;
      end
`ifdef UPDATE_BATTERY_EN
      WR_BAT: begin
        addr_nxt = BAT_BASE + (i_nxt << 1);
        wr_nxt   = 1'b1;
      end
`endif
      default: begin
        addr_nxt = 16'h0000;
        wr_nxt   = 1'b0;
      end
    endcase
    done_nxt = done_r | (state_nxt == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      i_r      <= 16'd0;
      cnt_r    <= 16'd0;
      found_r  <= 1'b0;
      q_new_r  <= 16'd0;
      addr_r   <= 16'd0;
      dout_r   <= 16'd0;
      wr_r     <= 1'b0;
      done_r   <= 1'b0;
      action_r <= 16'd0;
      rwd_r    <= 16'd0;
`ifdef UPDATE_BATTERY_EN
      bat_r    <= 16'd0;
`endif
    end else begin
      i_r      <= i_nxt;
      cnt_r    <= cnt_nxt;
      found_r  <= found_nxt;
      q_new_r  <= q_new_nxt;
      addr_r   <= addr_nxt;
      dout_r   <= dout_nxt;
      wr_r     <= wr_nxt;
      done_r   <= done_nxt;
      action_r <= action_nxt;
      rwd_r    <= rwd_nxt;
`ifdef UPDATE_BATTERY_EN
      bat_r    <= bat_nxt;
`endif
    end
  end

  // A held write strobe is masked while en is low so each write lands exactly once.
  assign mem.wr_en    = wr_r & en;
  assign mem.address  = addr_r;
  assign mem.data_out = dout_r;
  assign found        = found_r;
  assign q_new        = q_new_r;
  assign done         = done_r;

endmodule

// File: doc/qvalue_update.md
QVALUE_UPDATE -- requirements
Module: qvalue_update

Interface
REQ-001 Parameter ALPHA_SHIFT, default 2, learning-rate right-shift (alpha = 2^-ALPHA_SHIFT).
REQ-002 Parameter MAX_NEIGHBORS, default 64, maximum neighbor-table entries scanned.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  global enable; when low, the FSM holds state and wr_en is forced 0.
REQ-006 start  input  1  level trigger, driven by the upstream selectMyAction done.
REQ-007 action  input  16  neighbor ID chosen as next hop (selectMyAction output).
REQ-008 rwd  input  16  unsigned reward sample for that hop.
REQ-009 fbatteryStat  input  16  latest battery status reported by that hop.
REQ-010 address  output  16  memory address; byte address, word entries at 2-byte stride.
REQ-011 wr_en  output  1  memory write strobe, one cycle per write.
REQ-012 data_in  input  16  memory read data, valid one cycle after address is presented.
REQ-013 data_out  output  16  memory write data.
REQ-014 found  output  1  action matched a neighborID entry.
REQ-015 q_new  output  16  updated Q value, registered.
REQ-016 done  output  1  operation complete; sticky until rst.

Function
REQ-017 FSM states: IDLE, RD_CNT, LATCH_CNT, RD_ID, CMP_ID, RD_Q, CALC, WR_Q, WR_BAT, DONE.
REQ-018 IDLE -> RD_CNT when start=1, en=1 and done=0; action, rwd and fbatteryStat are latched on this edge.
REQ-019 RD_CNT: address=0x068A (neighborCount); next state is LATCH_CNT.
REQ-020 LATCH_CNT: cnt = min(data_in, MAX_NEIGHBORS); i=0; if cnt=0 go to DONE, else go to RD_ID.
REQ-021 RD_ID: address=0x0048+2*i; next state is CMP_ID.
REQ-022 CMP_ID: if data_in==action, set found=1 and go to RD_Q; else if i<cnt-1, i++ and go to RD_ID; else go to DONE with found=0 and no writes.
REQ-023 RD_Q: address=0x01C8+2*i; CALC latches Q=data_in.
REQ-024 CALC: if rwd>=Q, q_new = Q + ((rwd-Q)>>ALPHA_SHIFT); else q_new = Q - ((Q-rwd)>>ALPHA_SHIFT); 16-bit unsigned arithmetic; the result lies between Q and rwd, so it cannot overflow.
REQ-025 WR_Q: address=0x01C8+2*i, data_out=q_new, wr_en=1 for exactly one cycle; next state is WR_BAT if UPDATE_BATTERY_EN is defined, else DONE.
REQ-026 DONE: done=1; the FSM stays in DONE until rst, and ignores start.
REQ-027 Latency, match at index k: done rises 2k+7 edges after the start-sampling edge (2k+8 with UPDATE_BATTERY_EN).
REQ-028 Latency, no match with cnt=n: done rises 2n+2 edges after the start-sampling edge; with cnt=0: 2 edges.
REQ-029 Duplicate IDs: the first (lowest index) match wins.
REQ-030 wr_en=0 in every state except WR_Q and WR_BAT; address=0 in IDLE and DONE.
REQ-031 en low mid-operation: all registers hold; the next en-high cycle resumes in the same state with the same address.

Reset
REQ-032 rst=1 forces state=IDLE; address, data_out, q_new, i, cnt, found, wr_en and done all go to 0 immediately, independent of clock.
REQ-033 rst asserted mid-operation aborts the operation, and any pending write is dropped.

Configuration
REQ-034 Macro UPDATE_BATTERY_EN.
  - Defined: WR_BAT state present; address=0x0148+2*i, data_out=fbatteryStat, wr_en=1 for one cycle, then DONE.
  - Undefined: WR_BAT is absent and only the Q write occurs.

Verification
REQ-035 cnt=3, IDs {5,3,7}, action=3, Q[1]=10, rwd=30 -> one write, addr 0x01CA, data 15, found=1, done at edge 9.
REQ-036 cnt=2, IDs {3,8}, action=3, Q[0]=100, rwd=20 -> write 80 to 0x01C8, done at edge 7.
REQ-037 cnt=4, action=9 absent -> no wr_en pulse, found=0, done at edge 10.
REQ-038 cnt=0 -> done at edge 2, no ID reads, no writes.
REQ-039 en dropped for 3 cycles in CMP_ID -> state and address frozen, done delayed by exactly 3 cycles, result unchanged.
REQ-040 With UPDATE_BATTERY_EN, scenario REQ-035 plus fbatteryStat=0x8000 -> second write 0x8000 to 0x014A, done at edge 10.
